// File: rtl/fp_normalizer_if.sv
// rtl/fp_normalizer_if.sv - sample-in / unrounded-float-out handshake bundle
interface fp_normalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [2:0]  exp;
    logic [3:0]  sig;
    logic        fifth;

    modport master (
        output in_valid, d_in, out_ready,
        input  in_ready, out_valid, sign, exp, sig, fifth
    );

    modport slave (
        input  in_valid, d_in, out_ready,
        output in_ready, out_valid, sign, exp, sig, fifth
    );
endinterface

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - 12-bit two's-complement to sign/exp/significand normalizer
module fp_normalizer (
    input  logic               clk,
    input  logic               rst,
    fp_normalizer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ABS, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] d_q, d_d;
    logic [10:0] m_q, m_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sign_r_q, sign_r_d;
    logic        sign_q, sign_d;
    logic [2:0]  exp_q, exp_d;
    logic [3:0]  sig_q, sig_d;
    logic        fifth_q, fifth_d;

    logic [10:0] neg_low;
    logic [10:0] mag;

    // Low 11 bits of the negation are all that matter; -2048 has none set and saturates.
    assign neg_low = ~d_q[10:0] + 11'd1;
    assign mag     = !d_q[11]        ? d_q[10:0] :
                     (d_q == 12'h800) ? 11'h7FF   : neg_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        sign_r_d = sign_r_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        fifth_d  = fifth_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    d_d     = bus.d_in;
                    state_d = ABS;
                end
            end
            ABS: begin
                sign_r_d = d_q[11];
                m_d      = mag;
                cnt_d    = 3'd7;
                state_d  = NORM;
            end
            NORM: begin
                if (m_q[10] || cnt_q == 3'd0) begin
                    sign_d  = sign_r_q;
                    exp_d   = cnt_q;
                    sig_d   = m_q[10:7];
                    fifth_d = m_q[6];
                    state_d = DONE;
                end else begin
                    m_d   = {m_q[9:0], 1'b0};
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            sign_r_q <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            fifth_q  <= 1'b0;
        end else begin
            d_q      <= d_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            sign_r_q <= sign_r_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            fifth_q  <= fifth_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sign      = sign_q;
    assign bus.exp       = exp_q;
    assign bus.sig       = sig_q;
    assign bus.fifth     = fifth_q;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - scoreboard bench for fp_normalizer
module tb_fp_normalizer;
    logic clk = 1'b0;
    logic rst;

    fp_normalizer_if bus ();

    fp_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       sign;
        logic [2:0] ex;
        logic [3:0] sg;
        logic       fi;
        int         lat;
        int         acc;
    } res_t;

    res_t sb[$];
    res_t cur;
    bit   have_cur  = 0;
    bit   prev_ov   = 0;
    bit   rnd_ready = 0;
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   hs_cyc    = -1;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Reference: magnitude with saturation, then shift up to 7 places toward bit 10.
    function automatic res_t model(input logic [11:0] d);
        res_t e;
        int v, mag, k, sh;
        v   = int'($signed(d));
        mag = (v < 0) ? -v : v;
        if (mag > 2047) mag = 2047;
        k = 0;
        while (k < 7 && (mag << k) < 1024) k++;
        sh    = mag << k;
        e.sign = d[11];
        e.ex   = 3'(7 - k);
        e.sg   = 4'((sh >> 7) & 15);
        e.fi   = 1'((sh >> 6) & 1);
        e.lat  = k + 2;
        e.acc  = 0;
        return e;
    endfunction

    task automatic send(input logic [11:0] d, input bit push, output int acc);
        bit   take;
        res_t e;
        acc = -1;
        for (int b = 0; b < 300; b++) begin
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            take = bus.in_ready;
            bus.d_in = take ? d : 12'($urandom);
            @(negedge clk);
            if (take) begin
                acc = cyc;
                bus.in_valid = 1'b0;
                bus.d_in = 12'($urandom);
                if (push) begin
                    e = model(d);
                    e.acc = acc;
                    sb.push_back(e);
                end
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int b = 0; b < 400; b++) begin
            @(negedge clk);
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            if (sb.size() == 0 && !bus.out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            have_cur = 0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1;
                    check("sign", int'(bus.sign), int'(cur.sign));
                    check("exp", int'(bus.exp), int'(cur.ex));
                    check("sig", int'(bus.sig), int'(cur.sg));
                    check("fifth", int'(bus.fifth), int'(cur.fi));
                    check("latency", cyc - cur.acc, cur.lat);
                    check("in_ready_in_done", int'(bus.in_ready), 0);
                end
            end else if (have_cur) begin
                check(bus.out_valid ? "hold_stable" : "hold_after_handshake",
                      int'({bus.sign, bus.exp, bus.sig, bus.fifth}),
                      int'({cur.sign, cur.ex, cur.sg, cur.fi}));
            end
            if (!bus.out_valid && prev_ov) hs_cyc = cyc;
        end
        prev_ov = bus.out_valid;
    end

    initial begin
        logic [11:0] vec [5];
        int a, b2, seen;
        vec[0] = 12'h7FF; vec[1] = 12'h800; vec[2] = 12'h02D; vec[3] = 12'hFE7; vec[4] = 12'h000;

        bus.in_valid  = 1'b0;
        bus.d_in      = 12'h0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_fields", int'({bus.sign, bus.exp, bus.sig, bus.fifth}), 0);

        for (int i = 0; i < 5; i++) begin
            send(vec[i], 1, a);
            wait_idle();
        end

        // Stall in DONE, then a sample waiting on in_valid must land right after the handshake.
        bus.out_ready = 1'b0;
        send(12'h02D, 1, a);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        check("stall_reached_done", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        send(12'h5A3, 1, b2);
        check("back_to_back_accept", b2, hs_cyc + 1);
        wait_idle();

        // Reset in the middle of normalizing 0x001 discards the conversion.
        send(12'h001, 0, a);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_fields", int'({bus.sign, bus.exp, bus.sig, bus.fifth}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", int'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("rst_no_out_valid", seen, 0);

        rnd_ready = 1;
        for (int i = 0; i < 80; i++) begin
            send(12'($urandom) >> $urandom_range(0, 11), 1, a);
        end
        wait_idle();
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        wait_idle();
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  d_in holds a sample to convert.
REQ-006 in_ready  output  1  block can accept a sample; high only in IDLE.
REQ-007 d_in  input  12  two's-complement sample.
REQ-008 out_valid  output  1  sign/exp/sig/fifth hold a valid result.
REQ-009 out_ready  input  1  downstream rounding stage accepts the result.
REQ-010 sign  output  1  sign of the captured sample (d_in[11]).
REQ-011 exp  output  3  unrounded exponent, 0..7.
REQ-012 sig  output  4  unrounded significand: the 4 bits starting at the leading one.
REQ-013 fifth  output  1  bit immediately below sig, used downstream for rounding.

Function
REQ-014 The FSM SHALL have exactly 4 states: IDLE, ABS, NORM and DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1 at a rising edge, capture d_in and go to ABS; otherwise stay in IDLE.
REQ-016 ABS (1 cycle), which then goes to NORM:
- sign_r = d_in[11];
- m[10:0] = |d_in|, with -2048 (0x800) saturating to 2047;
- exp counter = 7.
REQ-017 NORM, evaluated once per cycle:
- if m[10]=1 or exp=0, register sig=m[10:7], fifth=m[6], exp, sign and go to DONE;
- else m = m<<1 (zero fill) and exp = exp-1.
REQ-018 Shift count k SHALL equal min(7, leading zeros of m in 11 bits) and is never more than 7.
REQ-019 Latency: out_valid SHALL rise exactly k+2 cycles after the accepting edge (2 minimum, 9 maximum).
REQ-020 DONE: out_valid=1; outputs SHALL stay stable while out_ready=0; on out_ready=1 at an edge, go to IDLE.
REQ-021 Throughput: no new sample SHALL be accepted before the DONE handshake; the earliest next acceptance is the cycle after it.
REQ-022 sign/exp/sig/fifth SHALL hold their last values after the handshake until the next result is registered.
REQ-023 For exp=0, sig SHALL equal the original magnitude bits [3:0] and fifth SHALL be 0.
REQ-024 Zero input SHALL yield sign=0, exp=0, sig=0, fifth=0.
REQ-025 in_valid SHALL be ignored in ABS, NORM and DONE; d_in is sampled only at the accepting edge.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE and clear out_valid, sign, exp, sig, fifth, m and the exp counter to 0, in any state.
REQ-027 Reset SHALL take priority over every handshake at the same edge.
REQ-028 A conversion interrupted by reset SHALL be discarded, with no out_valid pulse.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 d_in=0x7FF -> sign=0 exp=7 sig=1111 fifth=1; out_valid 2 cycles after accept.
REQ-031 d_in=0x800 -> saturates: sign=1 exp=7 sig=1111 fifth=1.
REQ-032 d_in=0x02D (45) -> sign=0 exp=2 sig=1011 fifth=0; k=5, latency 7.
REQ-033 d_in=0xFE7 (-25) -> sign=1 exp=1 sig=1100 fifth=1; d_in=0x000 -> all zero, latency 9.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; release -> IDLE the next cycle; a back-to-back in_valid is accepted only then.
REQ-035 Assert rst during NORM of 0x001 -> all outputs 0 next cycle, no out_valid, in_ready=1 after release.
